ifu_prefetch: RTL
=================

# ifu_prefetch

Instruction fetch unit upstream of decode. Holds the PC, issues word fetches to instruction memory over a request/grant handshake and collects in-order responses into a small buffer. Delivers {pc, inst} pairs to the decode stage over a valid/ready handshake. Supports PC redirect with flush and discard of stale in-flight responses.

## Interface
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset
- DEPTH, 2, buffer entries; also the maximum number of outstanding requests (power of two, at least 2)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- redirect_valid  in  1  load new PC this cycle
- redirect_pc  in  64  new PC; bits [1:0] ignored (treated as 0)
- imem_req  out  1  fetch request
- imem_addr  out  64  fetch address (word aligned)
- imem_gnt  in  1  request accepted when imem_req && imem_gnt
- imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant
- imem_rdata  in  32  response instruction
- id_valid  out  1  buffer head valid
- id_inst  out  32  head instruction
- id_pc  out  64  head PC
- id_ready  in  1  decode consumes head when id_valid && id_ready
- halted  out  1  fetch halted on EBREAK (tied 0 without IFU_EBREAK_HALT_EN)

## Operation
- States: BOOT, RUN, FLUSH (and HALT when configured).
- BOOT: entered on reset; imem_req=0; moves to RUN unconditionally next cycle.
- RUN: imem_req=1 iff count + outstanding < DEPTH; imem_addr = pc. On grant: pc += 4, outstanding += 1.
- Response: if drop_cnt == 0, push {pc_tag, imem_rdata} into buffer; pc_tag is a per-response PC queue or counter, equal to the granted address. Otherwise discard and drop_cnt -= 1. outstanding -= 1 on every response.
- Pop on id_valid && id_ready. Push and pop in the same cycle are legal in all occupancy states, including when the buffer is full.
- Redirect, highest priority, from any state except BOOT:
  - imem_req forced 0 that cycle.
  - pc <= {redirect_pc[63:2], 2'b00}.
  - Buffer cleared after any same-cycle pop.
  - drop_cnt <= outstanding - (imem_rvalid ? 1 : 0).
  - Next state: FLUSH if that value is nonzero, else RUN.
- FLUSH: imem_req=0; discard responses; go to RUN when drop_cnt reaches 0.
- Credit rule guarantees a response never arrives into a full buffer. An overflow is a bug; the bench must assert it never happens.
- Widths: pc 64-bit, wraps modulo 2^64. count and outstanding are clog2(DEPTH)+1 bits.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_inst=0, id_pc=0, halted=0; state=BOOT, count=outstanding=drop_cnt=0.
- First request is visible in the 2nd cycle after rst deasserts.
- imem_req and imem_addr are stable until granted; the address changes only on grant or redirect.
- Latency: rvalid in cycle N gives id_valid in cycle N+1 (registered buffer, no bypass).
- Zero-wait memory (gnt=1, rvalid exactly one cycle after grant) with id_ready=1 sustains 1 instruction per cycle with DEPTH=2.
- After redirect in cycle N with no outstanding requests: request for the new PC in cycle N+1.
- Reset asserted mid-operation: everything returns to reset values immediately. Memory responses still in flight are the memory's concern.

## Configuration
- IFU_EBREAK_HALT_EN defined: a pushed instruction equal to INST_EBREAK (32'h0010_0073) enters HALT after the push.
  - HALT: imem_req=0; in-flight responses are discarded; the buffer still drains to decode; halted=1.
  - Exit only via redirect (goes to FLUSH/RUN, halted=0) or reset.
- Undefined: EBREAK is an ordinary instruction, no HALT state, halted tied 0.

## Structure
- ifu_pkg: state enum, INST_EBREAK constant (same value as the existing global define), XLEN=64, ILEN=32.
- One sub-module, ifu_fifo: DEPTH-entry synchronous FIFO of {pc, inst} with push, pop, flush, count, full and empty, and async reset. ifu_prefetch holds the PC, the FSM and the credit and drop counters.

## Test plan
- Reset release, gnt=1, 1-cycle response, id_ready=1 -> addresses 0x8000_0000, _0004, _0008… one per cycle; id_pc matches; no gaps after fill.
- id_ready=0 for 10 cycles -> at most 2 grants, imem_req drops to 0, id_valid held with head pc 0x8000_0000; release -> in-order drain, no loss.
- gnt held low 5 cycles -> imem_req and imem_addr stable for all 5 cycles, a single grant on release.
- Redirect to 0x8000_0102 with 2 outstanding responses -> both discarded, next request addr 0x8000_0100, first delivered id_pc 0x8000_0100.
- Redirect in the same cycle as rvalid with outstanding=1 -> drop_cnt=0, direct to RUN, stale instruction never appears on id.
- With IFU_EBREAK_HALT_EN: stream containing 32'h0010_0073 at 0x8000_0008 -> delivered, then halted=1, no further requests; redirect to 0x8000_0000 resumes fetch.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

   localparam int XLEN = 64;
   localparam int ILEN = 32;

   localparam logic [ILEN-1:0] INST_EBREAK = 32'h0010_0073;

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_FLUSH,
      ST_HALT
   } ifu_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, inst}; flush clears it, overriding same-cycle push/pop.
module ifu_fifo
   import ifu_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic         i_flush,
   input  fetch_entry_t i_data,
   output fetch_entry_t o_data,
   output logic [CW-1:0] o_count,
   output logic         o_full,
   output logic         o_empty
);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_wr, r_rd;
   logic [CW-1:0] r_cnt;
   logic          w_wr, w_rd;

   assign w_wr    = i_push;
   assign w_rd    = i_pop && !o_empty;
   assign o_count = r_cnt;
   assign o_full  = (r_cnt == CW'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_data  = r_mem[r_rd];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_wr) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + AW'(1);
         end
         if (w_rd) r_rd <= r_rd + AW'(1);
         r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
      end
   end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: PC, fetch FSM, request credits and stale-response drop counter.
// Optional EBREAK halt is enabled by defining IFU_EBREAK_HALT_EN.
module ifu_prefetch
   import ifu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_gnt,
   input  logic            i_imem_rvalid,
   input  logic [ILEN-1:0] i_imem_rdata,
   output logic            o_id_valid,
   output logic [ILEN-1:0] o_id_inst,
   output logic [XLEN-1:0] o_id_pc,
   input  logic            i_id_ready,
   output logic            o_halted
);

   localparam int CW = $clog2(DEPTH) + 1;

   ifu_state_e      r_state, w_state_nxt;
   logic [XLEN-1:0] r_pc, r_tag, w_redir_pc;
   logic [CW-1:0]   r_out, r_drop, w_count, w_redir_drop;
   logic [CW:0]     w_credit;
   logic            w_redirect, w_push, w_pop, w_grant, w_full, w_empty, w_fifo_push;
   fetch_entry_t    w_head, w_in;

   assign w_redirect   = i_redirect_valid && (r_state != ST_BOOT);
   assign w_redir_pc   = i_redirect_pc & ~XLEN'(3);
   assign w_redir_drop = r_out - CW'(i_imem_rvalid);
   assign w_pop        = !w_empty && i_id_ready;
   // A same-cycle pop frees a slot, which keeps a zero-wait memory at one fetch per cycle.
   assign w_credit     = {1'b0, w_count} + {1'b0, r_out} - (CW+1)'(w_pop);
   assign w_grant      = o_imem_req && i_imem_gnt;
   assign w_fifo_push  = w_push && (!w_full || w_pop);
   assign w_in         = '{pc: r_tag, inst: i_imem_rdata};

   always_comb begin
      w_state_nxt = r_state;
      o_imem_req  = 1'b0;
      w_push      = 1'b0;
      case (r_state)
         ST_BOOT: w_state_nxt = ST_RUN;
         ST_RUN: begin
            o_imem_req = (w_credit < (CW+1)'(DEPTH));
            w_push     = i_imem_rvalid && (r_drop == '0);
`ifdef IFU_EBREAK_HALT_EN
            if (w_push && (i_imem_rdata == INST_EBREAK)) w_state_nxt = ST_HALT;
`endif
         end
         ST_FLUSH: begin
            if ((r_drop == '0) || (i_imem_rvalid && (r_drop == CW'(1))))
               w_state_nxt = ST_RUN;
         end
         default: ;
      endcase
      if (w_redirect) begin
         o_imem_req  = 1'b0;
         w_push      = 1'b0;
         w_state_nxt = (w_redir_drop != '0) ? ST_FLUSH : ST_RUN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_BOOT;
         r_pc    <= RESET_PC;
         r_tag   <= RESET_PC;
         r_out   <= '0;
         r_drop  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_out   <= r_out + CW'(w_grant) - CW'(i_imem_rvalid);
         if (w_redirect) begin
            r_pc   <= w_redir_pc;
            r_tag  <= w_redir_pc;
            r_drop <= w_redir_drop;
         end else begin
            if (w_grant) r_pc <= r_pc + XLEN'(4);
            if (w_fifo_push) r_tag <= r_tag + XLEN'(4);
            if (i_imem_rvalid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
         end
      end
   end

   ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_fifo_push),
      .i_pop   (w_pop),
      .i_flush (w_redirect),
      .i_data  (w_in),
      .o_data  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign o_imem_addr = r_pc;
   assign o_id_valid  = !w_empty;
   assign o_id_pc     = w_head.pc;
   assign o_id_inst   = w_head.inst;

`ifdef IFU_EBREAK_HALT_EN
   assign o_halted = (r_state == ST_HALT);
`else
   assign o_halted = 1'b0;
`endif

endmodule
